// File: rtl/onchip_ram_pkg.sv
// Shared definitions for the on-chip RAM arbiter.
//   ADDR_W / DATA_W / BE_W : default RAM geometry (16384 x 32-bit, 4 byte lanes)
//   master_id_e            : identifies which requester owns a transfer
//   ram_req_t              : one transfer as presented to the RAM port
package onchip_ram_pkg;

   localparam int ADDR_W = 14;
   localparam int DATA_W = 32;
   localparam int BE_W   = DATA_W / 8;

   typedef enum logic {
      M0 = 1'b0,
      M1 = 1'b1
   } master_id_e;

   typedef struct packed {
      logic [ADDR_W-1:0] address;
      logic [BE_W-1:0]   byteenable;
      logic              write;
      logic [DATA_W-1:0] writedata;
   } ram_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter with a registered last-grant pointer.
//   clk    : system clock
//   reset  : synchronous active-high reset; no grant while asserted
//   req    : request vector, bit i = master i
//   grant  : one-hot grant, combinational in the request cycle
//
// State (last_q):
//   state | meaning
//   M0    | m0 was granted most recently; m1 wins the next conflict
//   M1    | m1 was granted most recently (also the reset value); m0 wins next
module rr_arbiter2
   import onchip_ram_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   output logic [1:0] grant
);

   master_id_e last_q;
   master_id_e last_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         last_q <= M1;
      end else begin
         last_q <= last_d;
      end
   end

   always_comb begin
      grant  = 2'b00;
      last_d = last_q;
      if (!reset) begin
         unique case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_q == M1) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
         endcase
         if (grant[1]) begin
            last_d = M1;
         end else if (grant[0]) begin
            last_d = M0;
         end
      end
   end

endmodule

// File: rtl/onchip_ram_arbiter.sv
// Two-master arbiter in front of a single-port synchronous on-chip RAM.
// At most one transfer is issued per cycle; reads return after exactly one
// cycle with a per-master readdatavalid.
//   clk, reset                    : system clock, synchronous active-high reset
//   mN_address/byteenable/read/
//   write/writedata               : Avalon-style requests from master N
//   mN_waitrequest                : request not accepted this cycle
//   mN_readdata/readdatavalid     : read return path
//   ram_*                         : RAM slave port drive (ram_readdata is RAM q)
//   conflict_count, clear_count   : saturating count of both-requesting cycles
module onchip_ram_arbiter
   import onchip_ram_pkg::*;
#(
   parameter int ADDR_W = onchip_ram_pkg::ADDR_W,
   parameter int DATA_W = onchip_ram_pkg::DATA_W,
   parameter int CNT_W  = 16
) (
   input  logic                clk,
   input  logic                reset,

   input  logic [ADDR_W-1:0]   m0_address,
   input  logic [DATA_W/8-1:0] m0_byteenable,
   input  logic                m0_read,
   input  logic                m0_write,
   input  logic [DATA_W-1:0]   m0_writedata,
   output logic                m0_waitrequest,
   output logic [DATA_W-1:0]   m0_readdata,
   output logic                m0_readdatavalid,

   input  logic [ADDR_W-1:0]   m1_address,
   input  logic [DATA_W/8-1:0] m1_byteenable,
   input  logic                m1_read,
   input  logic                m1_write,
   input  logic [DATA_W-1:0]   m1_writedata,
   output logic                m1_waitrequest,
   output logic [DATA_W-1:0]   m1_readdata,
   output logic                m1_readdatavalid,

   output logic [ADDR_W-1:0]   ram_address,
   output logic [DATA_W/8-1:0] ram_byteenable,
   output logic                ram_chipselect,
   output logic                ram_write,
   output logic [DATA_W-1:0]   ram_writedata,
   output logic                ram_clken,
   input  logic [DATA_W-1:0]   ram_readdata,

   output logic [CNT_W-1:0]    conflict_count,
   input  logic                clear_count
);

   localparam int BE_W_L = DATA_W / 8;

   logic [1:0]        req;
   logic [1:0]        grant;
   logic              any_grant;

   logic [ADDR_W-1:0] sel_address;
   logic [BE_W_L-1:0] sel_byteenable;
   logic              sel_write;
   logic [DATA_W-1:0] sel_writedata;

   logic [ADDR_W-1:0] address_q;
   logic [BE_W_L-1:0] byteenable_q;
   logic [DATA_W-1:0] writedata_q;

   logic              tag_valid_q;
   master_id_e        tag_master_q;

   logic [CNT_W-1:0]  count_q;

   // Read+write together counts as a single request and is served as a write.
   assign req[0] = m0_read | m0_write;
   assign req[1] = m1_read | m1_write;

   rr_arbiter2 u_rr_arbiter2 (
      .clk   (clk),
      .reset (reset),
      .req   (req),
      .grant (grant)
   );

   assign any_grant = |grant;

   always_comb begin
      sel_address    = m0_address;
      sel_write      = m0_write;
      sel_writedata  = m0_writedata;
      sel_byteenable = m0_byteenable;
      if (grant[1]) begin
         sel_address    = m1_address;
         sel_write      = m1_write;
         sel_writedata  = m1_writedata;
         sel_byteenable = m1_byteenable;
      end
      if (!sel_write) begin
         sel_byteenable = '1;
      end
   end

   // Address/data hold the last granted transfer while the port is idle so
   // the RAM inputs do not toggle needlessly.
   always_ff @(posedge clk) begin
      if (reset) begin
         address_q    <= '0;
         byteenable_q <= '0;
         writedata_q  <= '0;
      end else if (any_grant) begin
         address_q    <= sel_address;
         byteenable_q <= sel_byteenable;
         writedata_q  <= sel_writedata;
      end
   end

   assign ram_address    = any_grant ? sel_address    : address_q;
   assign ram_byteenable = any_grant ? sel_byteenable : byteenable_q;
   assign ram_writedata  = any_grant ? sel_writedata  : writedata_q;
   assign ram_chipselect = any_grant;
   assign ram_write      = any_grant & sel_write;

   // Single-stage read tag: RAM q is valid exactly one cycle after the read.
   always_ff @(posedge clk) begin
      if (reset) begin
         tag_valid_q  <= 1'b0;
         tag_master_q <= M0;
      end else begin
         tag_valid_q <= any_grant & ~sel_write;
         if (any_grant) begin
            tag_master_q <= grant[1] ? M1 : M0;
         end
      end
   end

   // Keep the clock running through reset and for the readback cycle.
   assign ram_clken = reset | any_grant | tag_valid_q;

   assign m0_waitrequest = reset | (req[0] & ~grant[0]);
   assign m1_waitrequest = reset | (req[1] & ~grant[1]);

   // An outstanding read is dropped when reset lands on its return cycle.
   assign m0_readdatavalid = ~reset & tag_valid_q & (tag_master_q == M0);
   assign m1_readdatavalid = ~reset & tag_valid_q & (tag_master_q == M1);
   assign m0_readdata      = ram_readdata;
   assign m1_readdata      = ram_readdata;

   always_ff @(posedge clk) begin
      if (reset || clear_count) begin
         count_q <= '0;
      end else if (req[0] && req[1] && (count_q != '1)) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign conflict_count = count_q;

endmodule

// File: tb/tb_onchip_ram_arbiter.sv
module tb_onchip_ram_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [13:0] m0_address, m1_address;
   logic [3:0]  m0_byteenable, m1_byteenable;
   logic        m0_read, m1_read, m0_write, m1_write;
   logic [31:0] m0_writedata, m1_writedata;
   logic        m0_waitrequest, m1_waitrequest;
   logic [31:0] m0_readdata, m1_readdata;
   logic        m0_readdatavalid, m1_readdatavalid;
   logic [13:0] ram_address;
   logic [3:0]  ram_byteenable;
   logic        ram_chipselect, ram_write, ram_clken;
   logic [31:0] ram_writedata, ram_readdata;
   logic [15:0] conflict_count;
   logic        clear_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   onchip_ram_arbiter dut (
      .clk(clk), .reset(reset),
      .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
      .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
      .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
      .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
      .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
      .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
      .ram_address(ram_address), .ram_byteenable(ram_byteenable),
      .ram_chipselect(ram_chipselect), .ram_write(ram_write),
      .ram_writedata(ram_writedata), .ram_clken(ram_clken), .ram_readdata(ram_readdata),
      .conflict_count(conflict_count), .clear_count(clear_count)
   );

   // RAM model: registered address, unregistered q.
   logic [31:0] mem [0:16383];
   logic [13:0] raddr_q = '0;
   always @(posedge clk) begin
      if (ram_clken && ram_chipselect) begin
         if (ram_write) begin
            for (int b = 0; b < 4; b++)
               if (ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
         end
         raddr_q <= ram_address;
      end
   end
   assign ram_readdata = mem[raddr_q];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge; inputs are driven there.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
   endtask

   int m0_pulses, m1_pulses;

   initial begin
      reset = 1; clear_count = 0;
      idle();
      m0_address = '0; m1_address = '0; m0_byteenable = '0; m1_byteenable = '0;
      m0_writedata = '0; m1_writedata = '0;
      mem[14'h3FFF] = 32'h11223344;

      // Reset values
      tick(); tick();
      #2;
      check("rst_m0_wait", 32'(m0_waitrequest), 1);
      check("rst_m1_wait", 32'(m1_waitrequest), 1);
      check("rst_rdv", 32'({m0_readdatavalid, m1_readdatavalid}), 0);
      check("rst_cs_wr", 32'({ram_chipselect, ram_write}), 0);
      check("rst_clken", 32'(ram_clken), 1);
      check("rst_count", 32'(conflict_count), 0);
      tick();
      reset = 0;

      // 1: m0 write then read back
      m0_write = 1; m0_address = 14'h0010; m0_writedata = 32'hDEADBEEF; m0_byteenable = 4'hF;
      #2;
      check("t1_wr_wait", 32'(m0_waitrequest), 0);
      check("t1_wr_cs_wr", 32'({ram_chipselect, ram_write}), 32'b11);
      check("t1_wr_addr", 32'(ram_address), 32'h0010);
      check("t1_wr_data", ram_writedata, 32'hDEADBEEF);
      tick();
      m0_write = 0; m0_read = 1; m0_byteenable = 4'h0;
      #2;
      check("t1_rd_write", 32'(ram_write), 0);
      check("t1_rd_be", 32'(ram_byteenable), 32'hF);
      check("t1_rd_rdv_early", 32'(m0_readdatavalid), 0);
      tick();
      idle();
      #2;
      check("t1_rdv", 32'(m0_readdatavalid), 1);
      check("t1_rdata", m0_readdata, 32'hDEADBEEF);
      check("t1_m1_rdv", 32'(m1_readdatavalid), 0);
      tick();
      #2;
      check("t1_rdv_one_cycle", 32'(m0_readdatavalid), 0);

      // 2: m1 byte-lane write at top address, then read
      m1_write = 1; m1_address = 14'h3FFF; m1_writedata = 32'h000000AA; m1_byteenable = 4'b0001;
      tick();
      m1_write = 0; m1_read = 1;
      tick();
      idle();
      #2;
      check("t2_rdv", 32'(m1_readdatavalid), 1);
      check("t2_rdata", m1_readdata, 32'h112233AA);
      check("t2_m0_rdv", 32'(m0_readdatavalid), 0);
      check("t2_count", 32'(conflict_count), 0);
      tick();

      // 3: both masters read for 8 cycles; last grant was m1 so m0 goes first
      m0_pulses = 0; m1_pulses = 0;
      m0_read = 1; m1_read = 1;
      for (int i = 0; i < 8; i++) begin
         #2;
         check("t3_m0_wait", 32'(m0_waitrequest), (i % 2 == 1) ? 1 : 0);
         check("t3_m1_wait", 32'(m1_waitrequest), (i % 2 == 0) ? 1 : 0);
         if (i > 0) begin
            check("t3_m0_rdv", 32'(m0_readdatavalid), (i % 2 == 1) ? 1 : 0);
            check("t3_m1_rdv", 32'(m1_readdatavalid), (i % 2 == 0) ? 1 : 0);
            if (m0_readdatavalid) check("t3_m0_data", m0_readdata, 32'hDEADBEEF);
            if (m1_readdatavalid) check("t3_m1_data", m1_readdata, 32'h112233AA);
         end
         m0_pulses += int'(m0_readdatavalid);
         m1_pulses += int'(m1_readdatavalid);
         tick();
      end
      idle();
      #2;
      m0_pulses += int'(m0_readdatavalid);
      m1_pulses += int'(m1_readdatavalid);
      check("t3_m0_pulses", 32'(m0_pulses), 4);
      check("t3_m1_pulses", 32'(m1_pulses), 4);
      check("t3_last_m1_data", m1_readdata, 32'h112233AA);
      check("t3_count", 32'(conflict_count), 8);
      check("t3_readback_clken", 32'(ram_clken), 1);
      check("t3_readback_cs", 32'(ram_chipselect), 0);
      tick();

      // 4: idle bus
      for (int i = 0; i < 5; i++) begin
         #2;
         check("t4_cs", 32'(ram_chipselect), 0);
         check("t4_clken", 32'(ram_clken), 0);
         check("t4_wait", 32'({m0_waitrequest, m1_waitrequest}), 0);
         tick();
      end
      check("t4_addr_hold", 32'(ram_address), 32'h3FFF);

      // 5: reset on the readback cycle drops the read
      m0_read = 1; m0_address = 14'h0010;
      #2;
      check("t5_granted", 32'(m0_waitrequest), 0);
      tick();
      idle();
      reset = 1;
      #2;
      check("t5_rdv_in_reset", 32'({m0_readdatavalid, m1_readdatavalid}), 0);
      check("t5_wait_in_reset", 32'(m0_waitrequest), 1);
      tick();
      reset = 0;
      #2;
      check("t5_rdv_after", 32'({m0_readdatavalid, m1_readdatavalid}), 0);
      check("t5_count_cleared", 32'(conflict_count), 0);
      m0_read = 1; m1_read = 1;
      #1;
      check("t5_m0_wins", 32'({m0_waitrequest, m1_waitrequest}), 32'b01);
      tick();
      #2;
      check("t5_m1_next", 32'({m0_waitrequest, m1_waitrequest}), 32'b10);

      // 6: saturate the counter, then clear during contention
      for (int i = 0; i < 65540; i++) tick();
      #2;
      check("t6_saturated", 32'(conflict_count), 32'hFFFF);
      tick();
      #2;
      check("t6_holds", 32'(conflict_count), 32'hFFFF);
      clear_count = 1;
      tick();
      clear_count = 0;
      #2;
      check("t6_cleared", 32'(conflict_count), 0);
      tick();
      #2;
      check("t6_after_clear", 32'(conflict_count), 1);
      idle();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/onchip_ram_arbiter.md
Name: onchip_ram_arbiter

Overview:
- Two-requester, fixed-latency arbiter in front of the 16384 x 32-bit single-port on-chip RAM (14-bit word address, 4 byte enables).
- Shares the one RAM port between the processor data master (m0) and a DMA/accelerator master (m1).
- Issues at most one transfer per cycle and returns read data with a per-master readdatavalid.
- Sits between the interconnect and the RAM's s1-style slave port; also drives the RAM clock-enable for idle gating.

Parameters:
- ADDR_W, 14, RAM word-address width.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- CNT_W, 16, width of the saturating conflict counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- m0_address / m1_address  in  ADDR_W  word address.
- m0_byteenable / m1_byteenable  in  DATA_W/8  byte lanes; ignored for reads.
- m0_read / m1_read  in  1  read request.
- m0_write / m1_write  in  1  write request.
- m0_writedata / m1_writedata  in  DATA_W  write data.
- m0_waitrequest / m1_waitrequest  out  1  request not accepted this cycle.
- m0_readdata / m1_readdata  out  DATA_W  read data.
- m0_readdatavalid / m1_readdatavalid  out  1  readdata valid this cycle.
- ram_address  out  ADDR_W  to RAM.
- ram_byteenable  out  DATA_W/8  to RAM.
- ram_chipselect  out  1  to RAM.
- ram_write  out  1  to RAM.
- ram_writedata  out  DATA_W  to RAM.
- ram_clken  out  1  to RAM.
- ram_readdata  in  DATA_W  RAM q (unregistered output, valid the cycle after address is sampled).
- conflict_count  out  CNT_W  cycles in which both masters requested.
- clear_count  in  1  synchronous clear of conflict_count.

Behaviour:
- Request definition: req_i = mi_read | mi_write. If read and write are both high, the request is treated as a write (protocol error; no readdatavalid).
- Arbitration is combinational in the request cycle:
  - One requester: that requester is granted.
  - Both requesting: the master not granted last is granted (round-robin).
  - last_grant register updates on every granted cycle.
  - Reset value of last_grant = 1, so m0 wins the first conflict.
- waitrequest:
  - mi_waitrequest = req_i & ~grant_i, combinational.
  - Forced to 1 while reset = 1.
  - A master holds all its signals stable while waitrequest = 1 (Avalon rule; not checked).
- RAM drive, granted cycle:
  - ram_chipselect = 1.
  - ram_address / ram_byteenable / ram_writedata are muxed from the granted master.
  - ram_write = granted write.
  - Reads drive ram_byteenable = all ones.
- RAM drive, no grant: ram_chipselect = 0 and ram_write = 0; address/data hold the last granted values.
- ram_clken = 1 in any cycle with a grant or a pending readback; otherwise 0. Outputs are 1 during reset.
- Read latency is exactly 1:
  - A read granted in cycle T sets a registered tag {valid, master}.
  - In T+1, mi_readdatavalid = tag.valid & (tag.master == i), and mi_readdata = ram_readdata.
  - Both readdata outputs carry ram_readdata regardless of tag; only readdatavalid is qualified.
- Back-to-back reads from either or alternating masters sustain one transfer per cycle; the tag is a single-stage pipeline.
- Writes produce no response. Write-then-read to the same address in consecutive cycles returns the new data (port is sequential in time).
- conflict_count:
  - Increments in every cycle with req_0 & req_1, saturating at all ones.
  - clear_count has priority over increment.
  - Reset value 0.
- Reset mid-operation: the tag is cleared, so an outstanding read produces no readdatavalid. All outputs return to their reset values the cycle after reset is sampled.
- Output reset values:
  - waitrequest = 1.
  - readdatavalid = 0.
  - ram_chipselect = 0, ram_write = 0.
  - ram_clken = 1.
  - conflict_count = 0.

Decomposition:
- Shared package (onchip_ram_pkg):
  - ADDR_W, DATA_W, BE_W constants.
  - Typedef ram_req_t {address, byteenable, write, writedata}.
  - Enum master_id_e {M0, M1}.
- One natural sub-module: rr_arbiter2, which holds the two-input round-robin grant plus the last_grant register.

Test Plan:
1. m0 writes 0xDEADBEEF to addr 0x0010 with byteenable 4'hF; the next cycle m0 reads 0x0010 → m0_readdatavalid high exactly one cycle later, readdata 0xDEADBEEF, m1_readdatavalid stays 0.
2. m1 writes 0x000000AA with byteenable 4'b0001 over existing 0x11223344 at 0x3FFF, then reads it → 0x112233AA (byte lane plus top-address wrap check).
3. Both masters read every cycle for 8 cycles → grants alternate m0, m1, m0, …; each master sees 4 readdatavalid pulses in alternating cycles; conflict_count = 8.
4. Idle bus for 5 cycles → ram_chipselect = 0 and ram_clken = 0 from the cycle after the last readback; waitrequest = 0 for non-requesters.
5. m0 read granted, reset asserted the next cycle → no readdatavalid; after reset, the first conflict grants m0.
6. Force conflict_count to 0xFFFF via long contention → it holds at 0xFFFF; clear_count asserted in the same cycle as contention → value 0.
